// File: rtl/tiny_host_ctrl_pkg.sv
// Shared types and defaults for the tiny pairing core host controller.
package tiny_ctrl_pkg;

    localparam int W_DEF      = 198;
    localparam int AW_DEF     = 6;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_KICK,
        ST_WAIT,
        ST_RADDR,
        ST_RDATA,
        ST_ERR
    } state_e;

    // Bits needed to hold 0..n, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tiny_host_ctrl_if.sv
// Host-side operand/result streams of the controller.
interface tiny_host_ctrl_if
    import tiny_ctrl_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/tiny_host_ctrl_watchdog.sv
// Saturating cycle counter guarding the wait for core completion.
module tiny_ctrl_watchdog #(
    parameter int TO_W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic at_zero,
    output logic expired
);

    logic [TO_W-1:0] cnt_q, cnt_d;

    assign expired = &cnt_q;
    assign at_zero = (cnt_q == '0);

    // Clear wins; otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && !expired)
            cnt_d = cnt_q + TO_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tiny_host_ctrl.sv
// Host sequencer: load operands into core RAM, run the core, drain results.
module tiny_host_ctrl
    import tiny_ctrl_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int AW       = AW_DEF,
    parameter int IN_BASE  = 0,
    parameter int N_IN     = 6,
    parameter int OUT_BASE = 9,
    parameter int N_OUT    = 6,
    parameter int RD_LAT   = RD_LAT_DEF,
    parameter int TO_W     = 20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          err_timeout,
    tiny_host_ctrl_if.slave host,
    output logic          core_reset,
    output logic          core_sel,
    output logic [AW-1:0] core_addr,
    output logic          core_w,
    output logic [W-1:0]  core_data,
    input  logic [W-1:0]  core_out,
    input  logic          core_done
);

    localparam int CW = cnt_w((N_IN > N_OUT) ? N_IN : N_OUT);
    localparam int LW = cnt_w(RD_LAT);
    localparam logic [AW-1:0] IN_BASE_A  = AW'(IN_BASE);
    localparam logic [AW-1:0] OUT_BASE_A = AW'(OUT_BASE);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [LW-1:0]   lat_q, lat_d;
    logic            busy_q, busy_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic            err_q, err_d;
    logic            core_reset_q, core_reset_d;
    logic            core_sel_q, core_sel_d;
    logic [AW-1:0]   core_addr_q, core_addr_d;
    logic            core_w_q, core_w_d;
    logic [W-1:0]    core_data_q, core_data_d;
    logic            wd_first, wd_expired;

    // Timer only runs while waiting on the core; any other state holds it at zero.
    tiny_ctrl_watchdog #(.TO_W(TO_W)) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_q != ST_WAIT),
        .en      (state_q == ST_WAIT),
        .at_zero (wd_first),
        .expired (wd_expired)
    );

    assign cnt_inc = cnt_q + CW'(1);

    // Next-state and next-output logic; every output is set one cycle ahead.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        busy_d       = busy_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        err_d        = err_q;
        core_reset_d = core_reset_q;
        core_sel_d   = core_sel_q;
        core_addr_d  = core_addr_q;
        core_w_d     = 1'b0;
        core_data_d  = core_data_q;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                    err_d      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (host.in_valid && in_ready_q) begin
                    core_w_d    = 1'b1;
                    core_addr_d = IN_BASE_A + AW'(cnt_q);
                    core_data_d = host.in_data;
                    cnt_d       = cnt_inc;
                    if (cnt_q == CW'(N_IN - 1)) begin
                        in_ready_d = 1'b0;
                        state_d    = ST_KICK;
                    end
                end
            end
            ST_KICK: begin
                // Hold the core in reset for one cycle with its FSM owning the RAM port.
                core_sel_d   = 1'b0;
                core_reset_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                core_reset_d = 1'b0;
                core_sel_d   = 1'b0;
                // done seen in the first cycle predates the core's release, so skip it.
                if (core_done && !wd_first) begin
                    state_d      = ST_RADDR;
                    cnt_d        = '0;
                    lat_d        = '0;
                    core_reset_d = 1'b1;
                    core_sel_d   = 1'b1;
                    core_addr_d  = OUT_BASE_A;
                end else if (wd_expired) begin
                    state_d      = ST_ERR;
                    err_d        = 1'b1;
                    busy_d       = 1'b0;
                    core_reset_d = 1'b1;
                    core_sel_d   = 1'b1;
                end
            end
            ST_RADDR: begin
                // Address is on the port from the first RADDR cycle; core_out is valid RD_LAT later.
                if (lat_q == LW'(RD_LAT)) begin
                    out_data_d  = core_out;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == CW'(N_OUT - 1));
                    state_d     = ST_RDATA;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_RDATA: begin
                if (host.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d       = cnt_inc;
                        lat_d       = '0;
                        core_addr_d = OUT_BASE_A + AW'(cnt_inc);
                        state_d     = ST_RADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            lat_q        <= '0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            err_q        <= 1'b0;
            core_reset_q <= 1'b1;
            core_sel_q   <= 1'b1;
            core_addr_q  <= '0;
            core_w_q     <= 1'b0;
            core_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            err_q        <= err_d;
            core_reset_q <= core_reset_d;
            core_sel_q   <= core_sel_d;
            core_addr_q  <= core_addr_d;
            core_w_q     <= core_w_d;
            core_data_q  <= core_data_d;
        end
    end

    assign busy           = busy_q;
    assign err_timeout    = err_q;
    assign host.in_ready  = in_ready_q;
    assign host.out_valid = out_valid_q;
    assign host.out_last  = out_last_q;
    assign host.out_data  = out_data_q;
    assign core_reset     = core_reset_q;
    assign core_sel       = core_sel_q;
    assign core_addr      = core_addr_q;
    assign core_w         = core_w_q;
    assign core_data      = core_data_q;

endmodule

// File: tb/tb_tiny_host_ctrl.sv
// Directed bench for tiny_host_ctrl: main instance with a core model, plus a
// short-watchdog instance whose core never finishes.
module tb_tiny_host_ctrl;

    localparam int W  = 198;
    localparam int AW = 6;
    localparam int DONE_DLY = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- main instance ----------------
    logic          start = 1'b0, busy, err_timeout;
    logic          core_reset, core_sel, core_w, core_done;
    logic [AW-1:0] core_addr;
    logic [W-1:0]  core_data, core_out;
    tiny_host_ctrl_if #(.W(W)) h ();

    tiny_host_ctrl #(.W(W), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .err_timeout(err_timeout),
        .host(h), .core_reset(core_reset), .core_sel(core_sel), .core_addr(core_addr),
        .core_w(core_w), .core_data(core_data), .core_out(core_out), .core_done(core_done)
    );

    // Core model: RAM with one-cycle read, result words preset at 9..14, done DONE_DLY cycles after release.
    logic [W-1:0] ram [64];
    int rel_cnt;
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 6; i++) ram[9+i] <= W'(10 + i);
        end else if (core_sel && core_w) begin
            ram[core_addr] <= core_data;
        end
        core_out <= ram[core_addr];
        if (core_reset) begin
            rel_cnt   <= 0;
            core_done <= 1'b0;
        end else begin
            rel_cnt <= rel_cnt + 1;
            if (rel_cnt == DONE_DLY - 1) core_done <= 1'b1;
        end
    end

    // ---------------- watchdog instance ----------------
    logic          start2 = 1'b0, busy2, err2;
    logic          core_reset2, core_sel2, core_w2;
    logic [AW-1:0] core_addr2;
    logic [W-1:0]  core_data2;
    logic [W-1:0]  core_out2 = '0;
    logic          core_done2 = 1'b0;
    tiny_host_ctrl_if #(.W(W)) h2 ();

    tiny_host_ctrl #(.W(W), .AW(AW), .TO_W(4)) dut_to (
        .clk(clk), .reset(reset), .start(start2), .busy(busy2), .err_timeout(err2),
        .host(h2), .core_reset(core_reset2), .core_sel(core_sel2), .core_addr(core_addr2),
        .core_w(core_w2), .core_data(core_data2), .core_out(core_out2), .core_done(core_done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_words(input int base);
        for (int i = 0; i < 6; i++) begin
            h.in_valid = 1'b1;
            h.in_data  = W'(base + i);
            tick();
        end
        h.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        tick(); tick(); tick();
        v = {busy, h.in_ready, h.out_valid, h.out_last, err_timeout, core_reset, core_sel, core_w};
        n_checks++;
        if (v !== 8'b0000_0110) begin n_errors++; $display("FAIL reset_flags got %b want 00000110", v); end
        n_checks++;
        if (core_addr !== '0 || core_data !== '0) begin
            n_errors++; $display("FAIL reset_bus addr %0h data %0h want 0", core_addr, core_data);
        end
        reset = 1'b1;
        tick();
        start_job();
        for (int i = 0; i < 3; i++) begin
            h.in_valid = 1'b1; h.in_data = W'(8'h77 + i); tick();
        end
        h.in_valid = 1'b0;
        reset = 1'b0;
        tick();
        v = {busy, h.in_ready, h.out_valid, h.out_last, err_timeout, core_reset, core_sel, core_w};
        n_checks++;
        if (v !== 8'b0000_0110) begin n_errors++; $display("FAIL midload_reset_flags got %b want 00000110", v); end
        n_checks++;
        if (core_addr !== '0 || core_data !== '0) begin
            n_errors++; $display("FAIL midload_reset_bus addr %0h data %0h want 0", core_addr, core_data);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_load();
        start_job();
        n_checks++;
        if (busy !== 1'b1 || h.in_ready !== 1'b1) begin
            n_errors++; $display("FAIL start_accept busy %b in_ready %b want 1 1", busy, h.in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            h.in_valid = 1'b1;
            h.in_data  = W'(i + 1);
            tick();
            n_checks++;
            if (core_w !== 1'b1 || core_sel !== 1'b1 || core_addr !== AW'(i) || core_data !== W'(i + 1)) begin
                n_errors++;
                $display("FAIL load_write%0d w %b sel %b addr %0h data %0h want 1 1 %0h %0h",
                         i, core_w, core_sel, core_addr, core_data, i, i + 1);
            end
        end
        h.in_valid = 1'b0;
        n_checks++;
        if (h.in_ready !== 1'b0) begin n_errors++; $display("FAIL in_ready_drop got %b want 0", h.in_ready); end
        tick();
        n_checks++;
        if (core_w !== 1'b0 || core_sel !== 1'b0 || core_reset !== 1'b1) begin
            n_errors++; $display("FAIL kick w %b sel %b rst %b want 0 0 1", core_w, core_sel, core_reset);
        end
        tick();
        n_checks++;
        if (core_sel !== 1'b0 || core_reset !== 1'b0) begin
            n_errors++; $display("FAIL release sel %b rst %b want 0 0", core_sel, core_reset);
        end
    endtask

    task automatic test_drain();
        int k = 0;
        h.out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && k < 6; cyc++) begin
            if (h.out_valid) begin
                n_checks++;
                if (h.out_data !== W'(10 + k) || h.out_last !== (k == 5)) begin
                    n_errors++;
                    $display("FAIL drain_word%0d data %0h last %b want %0h %b",
                             k, h.out_data, h.out_last, 10 + k, (k == 5));
                end
                k++;
            end
            tick();
        end
        n_checks++;
        if (k != 6) begin n_errors++; $display("FAIL drain_count got %0d want 6", k); end
        n_checks++;
        if (busy !== 1'b0 || h.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL drain_end busy %b out_valid %b want 0 0", busy, h.out_valid);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        logic stalled = 1'b0, plast = 1'b0;
        logic [W-1:0] pdata = '0;
        start_job();
        load_words(8'h11);
        for (int cyc = 0; cyc < 2000 && k < 6; cyc++) begin
            h.out_ready = 1'($urandom_range(0, 1));
            if (stalled) begin
                n_checks++;
                if (h.out_valid !== 1'b1 || h.out_data !== pdata || h.out_last !== plast) begin
                    n_errors++;
                    $display("FAIL stall_hold valid %b data %0h last %b want 1 %0h %b",
                             h.out_valid, h.out_data, h.out_last, pdata, plast);
                end
            end
            if (h.out_valid) begin
                n_checks++;
                if (h.out_data !== W'(10 + k) || h.out_last !== (k == 5)) begin
                    n_errors++;
                    $display("FAIL bp_word%0d data %0h last %b want %0h %b",
                             k, h.out_data, h.out_last, 10 + k, (k == 5));
                end
            end
            stalled = h.out_valid && !h.out_ready;
            pdata   = h.out_data;
            plast   = h.out_last;
            if (h.out_valid && h.out_ready) k++;
            tick();
        end
        n_checks++;
        if (k != 6 || busy !== 1'b0) begin
            n_errors++; $display("FAIL bp_count got %0d busy %b want 6 0", k, busy);
        end
        h.out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n = 0, lo = 0;
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            h2.in_valid = 1'b1; h2.in_data = W'(i); tick();
        end
        h2.in_valid = 1'b0;
        while (core_reset2 && n < 10) begin n++; tick(); end
        while (!core_reset2 && lo < 100) begin lo++; tick(); end
        n_checks++;
        if (lo != 15) begin n_errors++; $display("FAIL wait_cycles got %0d want 15", lo); end
        n_checks++;
        if (err2 !== 1'b1 || busy2 !== 1'b0 || core_reset2 !== 1'b1 || core_sel2 !== 1'b1) begin
            n_errors++;
            $display("FAIL err_state err %b busy %b rst %b sel %b want 1 0 1 1", err2, busy2, core_reset2, core_sel2);
        end
        tick(); tick();
        n_checks++;
        if (err2 !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b want 1", err2); end
        start2 = 1'b1; tick(); start2 = 1'b0;
        n_checks++;
        if (err2 !== 1'b0 || busy2 !== 1'b1 || h2.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL err_restart err %b busy %b in_ready %b want 0 1 1", err2, busy2, h2.in_ready);
        end
    endtask

    task automatic test_gapped();
        int k = 0, d = 0;
        logic acc;
        start_job();
        for (int c = 0; c < 18; c++) begin
            h.in_valid = (c % 3 == 0);
            h.in_data  = W'(8'h21 + k);
            start      = (c == 4);
            acc        = h.in_valid && h.in_ready;
            tick();
            n_checks++;
            if (acc) begin
                if (core_w !== 1'b1 || core_addr !== AW'(k) || core_data !== W'(8'h21 + k)) begin
                    n_errors++;
                    $display("FAIL gap_write%0d w %b addr %0h data %0h want 1 %0h %0h",
                             k, core_w, core_addr, core_data, k, 8'h21 + k);
                end
                k++;
            end else if (core_w !== 1'b0) begin
                n_errors++; $display("FAIL gap_idle%0d w %b want 0", c, core_w);
            end
        end
        h.in_valid = 1'b0;
        start      = 1'b0;
        n_checks++;
        if (k != 6 || h.in_ready !== 1'b0) begin
            n_errors++; $display("FAIL gap_count got %0d in_ready %b want 6 0", k, h.in_ready);
        end
        start = 1'b1; tick(); start = 1'b0;
        n_checks++;
        if (h.in_ready !== 1'b0 || busy !== 1'b1 || core_reset !== 1'b0) begin
            n_errors++;
            $display("FAIL start_in_wait in_ready %b busy %b rst %b want 0 1 0", h.in_ready, busy, core_reset);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (ram[i] !== W'(8'h21 + i)) begin
                n_errors++; $display("FAIL ram%0d got %0h want %0h", i, ram[i], 8'h21 + i);
            end
        end
        h.out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && d < 6; cyc++) begin
            if (h.out_valid) begin
                n_checks++;
                if (h.out_data !== W'(10 + d) || h.out_last !== (d == 5)) begin
                    n_errors++;
                    $display("FAIL gap_drain%0d data %0h last %b want %0h %b",
                             d, h.out_data, h.out_last, 10 + d, (d == 5));
                end
                d++;
            end
            tick();
        end
        n_checks++;
        if (d != 6 || busy !== 1'b0) begin
            n_errors++; $display("FAIL gap_drain_count got %0d busy %b want 6 0", d, busy);
        end
    endtask

    initial begin
        h.in_valid   = 1'b0;
        h.in_data    = '0;
        h.out_ready  = 1'b0;
        h2.in_valid  = 1'b0;
        h2.in_data   = '0;
        h2.out_ready = 1'b1;
        test_reset();
        test_load();
        test_drain();
        test_backpressure();
        test_timeout();
        test_gapped();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
